pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port stallreq_if, input, 1, IF stage (instruction fetch wait) stall request.
REQ-004 SHALL have port stallreq_id, input, 1, ID stage (load-use hazard) stall request.
REQ-005 SHALL have port stallreq_ex, input, 1, EX stage (multi-cycle mul/div) stall request.
REQ-006 SHALL have port stallreq_mem, input, 1, MEM stage (data bus wait) stall request.
REQ-007 SHALL have port exc_code_i, input, EXC_CODE_WIDTH, exception code of instruction in MEM; EC_NONE = no exception.
REQ-008 SHALL have port cp0_epc_i, input, 32, current CP0 EPC, ERET target.
REQ-009 SHALL have port stall, output, 6, per-stage hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; STOP = 1.
REQ-010 SHALL have port flush, output, 1, clears all pipeline registers at the next edge.
REQ-011 SHALL have port new_pc, output, 32, PC redirect target, valid only while flush = 1.
REQ-012 SHALL have port stall_timeout, output, 1, watchdog flag.
REQ-013 SHALL have port stall_cycles, output, 32, performance counter of cycles with stall != 0.
REQ-014 SHALL have parameter WDT_LIMIT, default 16'd1024, consecutive stall cycles before stall_timeout.

Function
REQ-015 SHALL implement a two-state FSM: RUN, FLUSH.
REQ-016 In RUN with exc_code_i == EC_NONE, stall SHALL be decoded combinationally with priority mem > ex > id > if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; else 6'b000000.
REQ-017 In RUN with exc_code_i != EC_NONE, stall SHALL be 6'b011111 that cycle, regardless of stall requests, so that MEM/WB loads a bubble, not the faulting instruction.
REQ-018 In RUN with exc_code_i != EC_NONE, FSM SHALL go to FLUSH at the next edge, registering target: cp0_epc_i if exc_code_i == EC_ERET, else EXC_VECTOR (32'hBFC00380).
REQ-019 In FLUSH, flush SHALL be 1, new_pc SHALL equal the registered target, stall SHALL be 6'b000000; FSM SHALL return to RUN at the next edge unconditionally.
REQ-020 exc_code_i and all stall requests SHALL be ignored in FLUSH.
REQ-021 In RUN, flush SHALL be 0 and new_pc SHALL be 32'h0.
REQ-022 A 16-bit watchdog counter SHALL increment each RUN cycle with stall != 0, clear to 0 on any cycle with stall == 0 or in FLUSH, and saturate at 16'hFFFF.
REQ-023 stall_timeout SHALL be 1 combinationally while watchdog counter >= WDT_LIMIT.
REQ-024 stall_cycles SHALL increment by 1 on each edge where stall != 0, wrapping from 32'hFFFFFFFF to 0.

Reset
REQ-025 While rst = 0: FSM = RUN, registered target = 32'h0, watchdog = 0, stall_cycles = 0; hence stall = 6'b0, flush = 0, new_pc = 32'h0, stall_timeout = 0.
REQ-026 Reset asserted during FLUSH SHALL abort the flush immediately (flush = 0 while rst = 0).

Structure
REQ-027 EXC_CODE_WIDTH, EC_NONE, EC_ERET, EXC_VECTOR, STOP/NOSTOP SHALL come from the shared defines file; stall-vector patterns SHALL be defined as named constants there.
REQ-028 Watchdog SHALL be a sub-module stall_watchdog (inputs stall_active, clear; output timeout).

Verification
REQ-029 stallreq_ex = 1, stallreq_id = 1 for 3 cycles -> stall = 6'b001111 each cycle, stall_cycles = 3.
REQ-030 exc_code_i = syscall code with stallreq_mem = 1 -> stall = 6'b011111 same cycle; next cycle flush = 1, new_pc = 32'hBFC00380, stall = 0; then flush = 0.
REQ-031 exc_code_i = EC_ERET, cp0_epc_i = 32'h80001234 -> next cycle flush = 1, new_pc = 32'h80001234, for exactly one cycle.
REQ-032 Exception held for 2 consecutive cycles -> single flush pulse; second cycle (FLUSH) ignores it; third cycle re-detects only if still != EC_NONE.
REQ-033 WDT_LIMIT = 4, stallreq_mem held 6 cycles -> stall_timeout rises after 4th stalled edge, drops the cycle stall returns to 0.
REQ-034 rst = 0 asserted mid-FLUSH -> flush, stall, stall_cycles, stall_timeout all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control slice: exception code width
// and values, the exception vector, hold polarity, the per-stage stall
// vector patterns and the controller state type.
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int EXC_CODE_WIDTH = 5;

  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h00;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_INT     = 5'h01;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL    = 5'h04;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES    = 5'h05;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_BREAK   = 5'h09;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_RI      = 5'h0A;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_OV      = 5'h0C;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h1E;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  // Hold polarity of a single stall bit.
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB,
  // bit5 WB. A request from a stage holds that stage and everything
  // upstream of it; WB itself is never held.
  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  // An excepting instruction in MEM must not reach WB, so MEM/WB is held
  // and loads a bubble while the redirect is being set up.
  localparam logic [STALL_W-1:0] STALL_EXC  = STALL_MEM;

  localparam int WDT_W = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  // Redirect target for a detected exception: ERET returns to EPC, all
  // other codes go to the common exception vector.
  function automatic logic [31:0] exc_target(
    input logic [EXC_CODE_WIDTH-1:0] code,
    input logic [31:0]               epc
  );
    return (code == EC_ERET) ? epc : EXC_VECTOR;
  endfunction

endpackage : pipeline_ctrl_pkg

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// ---------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive stalled cycles and flags a pipeline that has been held
// for WDT_LIMIT cycles or more.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active low
//   stall_active : the pipeline is held this cycle
//   clear        : force the count to zero at the next edge
//   timeout      : count >= WDT_LIMIT while the pipeline is still held
// ---------------------------------------------------------------------------
module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [WDT_W-1:0] WDT_LIMIT = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  input  logic clear,
  output logic timeout
);

  localparam logic [WDT_W-1:0] WDT_MAX = '1;

  logic [WDT_W-1:0] wdt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt <= '0;
    end else if (clear || !stall_active) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_MAX) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // The count is only zeroed at the edge closing a stall-free cycle, so the
  // flag is qualified with stall_active to drop in that same cycle.
  assign timeout = stall_active && (wdt_cnt >= WDT_LIMIT);

endmodule : stall_watchdog

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall and flush controller for a five-stage pipeline. Decodes per-stage
// stall requests into a hold vector, turns an exception reported from MEM
// into a one-cycle flush with a PC redirect, watches for runaway stalls and
// counts stalled cycles.
//
// State table
//   state    | meaning
//   ST_RUN   | normal flow; stall decoded from requests, exception detect
//   ST_FLUSH | one cycle: flush = 1, new_pc = captured target, no stall
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous reset, active low
//   stallreq_if   : IF stage fetch-wait stall request
//   stallreq_id   : ID stage load-use stall request
//   stallreq_ex   : EX stage multi-cycle mul/div stall request
//   stallreq_mem  : MEM stage data-bus wait stall request
//   exc_code_i    : exception code of the instruction in MEM
//   cp0_epc_i     : current CP0 EPC (ERET target)
//   stall         : per-stage hold vector, 1 = hold
//   flush         : clear all pipeline registers at the next edge
//   new_pc        : redirect target, valid only while flush = 1
//   stall_timeout : pipeline held for WDT_LIMIT consecutive cycles or more
//   stall_cycles  : count of cycles with stall != 0 (wraps)
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [WDT_W-1:0] WDT_LIMIT = 16'd1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stallreq_if,
  input  logic                      stallreq_id,
  input  logic                      stallreq_ex,
  input  logic                      stallreq_mem,
  input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic [31:0]               cp0_epc_i,
  output logic [STALL_W-1:0]        stall,
  output logic                      flush,
  output logic [31:0]               new_pc,
  output logic                      stall_timeout,
  output logic [31:0]               stall_cycles
);

  ctrl_state_e state;
  logic [31:0] target;
  logic        exc_valid;
  logic        stall_active;
  logic        in_flush;

  assign exc_valid = (exc_code_i != EC_NONE);
  assign in_flush  = (state == ST_FLUSH);

  // Gated with rst so the hold vector is quiet during reset even though it
  // is a combinational decode of live requests.
  always_comb begin
    stall = STALL_NONE;
    if (rst && (state == ST_RUN)) begin
      if (exc_valid) begin
        stall = STALL_EXC;
      end else if (stallreq_mem == STOP) begin
        stall = STALL_MEM;
      end else if (stallreq_ex == STOP) begin
        stall = STALL_EX;
      end else if (stallreq_id == STOP) begin
        stall = STALL_ID;
      end else if (stallreq_if == STOP) begin
        stall = STALL_IF;
      end
    end
  end

  assign stall_active = (stall != STALL_NONE);

  // Requests and exception codes are not looked at in ST_FLUSH; the
  // controller always spends exactly one cycle there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      target <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_valid) begin
            state  <= ST_FLUSH;
            target <= exc_target(exc_code_i, cp0_epc_i);
          end
        end
        ST_FLUSH: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Async reset drops the state to ST_RUN, which aborts a flush at once.
  assign flush  = in_flush;
  assign new_pc = in_flush ? target : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0;
    end else if (stall_active) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  stall_watchdog #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_stall_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall_active),
    .clear        (in_flush),
    .timeout      (stall_timeout)
  );

endmodule : pipeline_ctrl
